// File: rtl/census_disp_feeder_if.sv
// Census pair stream in, pixel/window stream out, between the census stage and the SGM core.
interface census_disp_feeder_if #(
    parameter int censusVecW = 24,
    parameter int dispLevel  = 32,
    parameter int ImageW     = 640,
    parameter int ImageH     = 480
);
    logic                            in_valid;
    logic                            in_sof;
    logic [censusVecW-1:0]           in_censusL;
    logic [censusVecW-1:0]           in_censusR;
    logic                            out_valid;
    logic [censusVecW-1:0]           PixData;
    logic [censusVecW*dispLevel-1:0] LineData;
    logic                            IsOnEdge;
    logic [$clog2(ImageW)-1:0]       col;
    logic [$clog2(ImageH)-1:0]       row;
    logic                            frame_done;
    logic                            sof_err;

    modport master (
        output in_valid, in_sof, in_censusL, in_censusR,
        input  out_valid, PixData, LineData, IsOnEdge, col, row, frame_done, sof_err
    );
    modport slave (
        input  in_valid, in_sof, in_censusL, in_censusR,
        output out_valid, PixData, LineData, IsOnEdge, col, row, frame_done, sof_err
    );
endinterface

// File: rtl/census_disp_feeder.sv
// Sliding window of right census vectors feeding the SGM cost stage, one pixel per accept.
// Optional CENSUS_FEEDER_LINECLR_EN: zero carried slots when a line starts.
module census_disp_feeder #(
    parameter int censusVecW   = 24,
    parameter int dispLevel    = 32,
    parameter int ImageW       = 640,
    parameter int ImageH       = 480,
    parameter int CensusMargin = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    census_disp_feeder_if.slave  bus
);
    localparam int CW = $clog2(ImageW);
    localparam int RW = $clog2(ImageH);

    logic [CW-1:0] r_ncol;
    logic [RW-1:0] r_nrow;
    logic [dispLevel-1:0][censusVecW-1:0] r_win;
    logic [censusVecW-1:0] r_pix;
    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic                  r_out_valid, r_edge, r_fd, r_err;

    logic          w_acc, w_col_last, w_row_last, w_edge;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [dispLevel-1:0][censusVecW-1:0] w_win_nxt;

    assign w_acc      = en & bus.in_valid;
    // in_sof overrides the running position so a resync always lands on (0,0)
    assign w_col      = bus.in_sof ? '0 : r_ncol;
    assign w_row      = bus.in_sof ? '0 : r_nrow;
    assign w_col_last = (w_col == CW'(ImageW-1));
    assign w_row_last = (w_row == RW'(ImageH-1));

    assign w_edge = (int'(w_col) <  dispLevel-1)           ||
                    (int'(w_col) <  CensusMargin)          ||
                    (int'(w_col) >= ImageW-CensusMargin)   ||
                    (int'(w_row) <  CensusMargin)          ||
                    (int'(w_row) >= ImageH-CensusMargin);

    always_comb begin
        w_win_nxt    = r_win;
        w_win_nxt[0] = bus.in_censusR;
        for (int d = 1; d < dispLevel; d++) begin
`ifdef CENSUS_FEEDER_LINECLR_EN
            w_win_nxt[d] = (w_col == '0) ? '0 : r_win[d-1];
`else
            w_win_nxt[d] = r_win[d-1];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ncol      <= '0;
            r_nrow      <= '0;
            r_win       <= '0;
            r_pix       <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_out_valid <= 1'b0;
            r_edge      <= 1'b0;
            r_fd        <= 1'b0;
            r_err       <= 1'b0;
        end else if (en) begin
            r_out_valid <= w_acc;
            r_fd        <= w_acc & w_col_last & w_row_last;
            if (w_acc) begin
                r_win  <= w_win_nxt;
                r_pix  <= bus.in_censusL;
                r_col  <= w_col;
                r_row  <= w_row;
                r_edge <= w_edge;
                r_ncol <= w_col_last ? '0 : w_col + 1'b1;
                if (w_col_last) r_nrow <= w_row_last ? '0 : w_row + 1'b1;
                else            r_nrow <= w_row;
                if (bus.in_sof && (r_ncol != '0 || r_nrow != '0)) r_err <= 1'b1;
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.PixData    = r_pix;
    assign bus.LineData   = r_win;
    assign bus.IsOnEdge   = r_edge;
    assign bus.col        = r_col;
    assign bus.row        = r_row;
    assign bus.frame_done = r_fd;
    assign bus.sof_err    = r_err;
endmodule
